mmio_pwm: RTL
=============

# mmio_pwm

Memory-mapped, multi-channel PWM peripheral for the RISC-V processor's I/O region. It replaces the fixed LED/RGB output drive with NUM_CH independently programmable duty-cycle outputs. All channels share a prescaler and a period, and period and duty updates are double-buffered so they always take effect on a period boundary. A sticky wrap flag and an interrupt line let firmware pace its updates.

## Interface
Parameters:
- NUM_CH, 4: number of PWM channels, 1..16.
- CNT_W, 8: width of the period counter and of the duty registers, 2..16.
- PRE_W, 16: width of the prescaler.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  peripheral selected by the processor's address decode.
- we  in  1  write strobe. Qualified by sel.
- re  in  1  read strobe. Qualified by sel.
- addr  in  8  byte offset. Word aligned; addr[1:0] is ignored.
- wdata  in  32  write data.
- wmask  in  4  byte-lane write enables.
- rdata  out  32  read data, registered.
- pwm_out  out  NUM_CH  PWM outputs, registered.
- irq  out  1  level interrupt = STATUS.WRAP & CTRL.IE.

## Operation
- Register map (offset: name):
  - 0x00 CTRL: [0] EN, [1] INV (invert all outputs), [2] IE.
  - 0x04 PRESCALE: [PRE_W-1:0].
  - 0x08 PERIOD: [CNT_W-1:0], shadow register.
  - 0x0C STATUS: [0] WRAP, write-1-to-clear.
  - 0x10+4*i DUTY[i]: [CNT_W-1:0], shadow register, for i < NUM_CH.
- Unmapped offsets read 0, and writes to them are ignored. Unimplemented bits read 0. wmask applies per byte on every register.
- Prescaler: pre_cnt counts 0..PRESCALE while EN=1. A tick is generated when pre_cnt == PRESCALE, and pre_cnt then returns to 0. PRESCALE=0 gives a tick every cycle.
- Counter: cnt increments on each tick. A tick with cnt == period_act sets cnt to 0 and raises a wrap event.
- Wrap event:
  - period_act <= PERIOD shadow; duty_act[i] <= DUTY[i] shadow.
  - STATUS.WRAP <= 1.
- EN=0:
  - pre_cnt and cnt are held at 0.
  - Active registers continuously track the shadows.
  - pwm_out is driven to the INV value.
- Output: pwm_out[i] <= EN ? ((cnt < duty_act[i]) ^ INV) : INV.
  - duty 0 gives a constant inactive level.
  - duty > period_act gives a constant active level.
  - Effective period is (period_act+1)*(PRESCALE+1) cycles.
- Simultaneous events:
  - A shadow write in the same cycle as a wrap: the wrap loads the old shadow value, and the new value applies at the next wrap.
  - A W1C of WRAP in the same cycle as a wrap event: set wins, WRAP stays 1.
  - we and re together: the read returns the pre-write value.
- Reset values:
  - CTRL=0, PRESCALE=0, STATUS=0, DUTY=0.
  - PERIOD and period_act = 2^CNT_W-1.
  - cnt=0, pre_cnt=0.
  - pwm_out=0, rdata=0, irq=0.

## Timing
- Register write: the new value is visible to a read issued the following cycle.
- Read latency: rdata is valid 1 cycle after sel&re, and holds its value until the next read.
- Output latency: pwm_out reflects cnt with 1 cycle of latency. Its first active edge after EN goes 0->1 is 1 cycle later, provided duty_act>0.
- Wrap: the shadow load and WRAP set happen on the same edge that cnt returns to 0. irq is asserted the cycle after that edge.
- Mid-operation rst clears every register and output on the next edge, regardless of tick or wrap state.

## Structure
- Package pwm_pkg holds:
  - Register offset localparams (CTRL_OFS, PRESCALE_OFS, PERIOD_OFS, STATUS_OFS, DUTY_BASE).
  - CTRL bit-index constants.
- Sub-module pwm_channel holds one shadow/active duty pair, the comparator and the output flop. It is instantiated NUM_CH times by a generate loop.
- The top level holds the bus decode, prescaler, counter, STATUS and read mux.

## Test plan
- Reset: assert rst for 2 cycles, then read all registers. Required: CTRL=0, PERIOD=0xFF, DUTY=0, pwm_out=0, irq=0.
- Basic PWM: PERIOD=9, PRESCALE=0, DUTY[0]=3, EN=1. Required: pwm_out[0] high for 3 of every 10 cycles, and WRAP set every 10 cycles.
- Double buffering: while running, write DUTY[0]=7 at cnt=5. Required: the current period keeps its 3-cycle high phase, and the next period is high for 7 cycles. Also write the shadow in the exact wrap cycle and check that the change is delayed by one period.
- Limits and INV:
  - DUTY[1]=0 gives constant low.
  - DUTY[2]=12 with PERIOD=9 gives constant high.
  - INV=1 inverts both.
  - PRESCALE=2 gives a 30-cycle period.
- STATUS/irq:
  - With IE=1, irq rises after a wrap.
  - Writing 1 to STATUS[0] clears it.
  - A W1C coinciding with a wrap leaves WRAP=1.
- Bus edge cases:
  - A write with wmask=4'b0001 to PERIOD=0x1234 gives PERIOD=0x34.
  - An unmapped read at 0x80 returns 0.
  - rst asserted mid-period returns all outputs to 0 on the next edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the mmio_pwm peripheral.
//   - Register byte offsets of the memory-mapped register file.
//   - CTRL bit positions.
//   - merge_bytes(): applies a byte-lane write mask to a register value.
package pwm_pkg;

   localparam logic [7:0] CTRL_OFS     = 8'h00;
   localparam logic [7:0] PRESCALE_OFS = 8'h04;
   localparam logic [7:0] PERIOD_OFS   = 8'h08;
   localparam logic [7:0] STATUS_OFS   = 8'h0C;
   localparam logic [7:0] DUTY_BASE    = 8'h10;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_INV = 1;
   localparam int CTRL_IE  = 2;
   localparam int CTRL_W   = 3;

   // Byte lanes with mask[b]=1 take the new value, the others keep the old one.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = mask[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output.
//   Holds the shadow duty register (bus-written), the active duty register
//   (loaded on a period boundary, or continuously while disabled), the
//   duty comparator and the registered output.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   wr            write strobe for this channel's DUTY register
//   wdata, wmask  bus write data and byte-lane enables
//   load          copy shadow -> active this cycle
//   en, inv       CTRL.EN and CTRL.INV
//   cnt           shared period counter
//   duty_sh       shadow duty value (for bus read-back)
//   pwm           registered PWM output
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [31:0]      wdata,
   input  logic [3:0]       wmask,
   input  logic             load,
   input  logic             en,
   input  logic             inv,
   input  logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] duty_sh,
   output logic             pwm
);

   logic [CNT_W-1:0] duty_act;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values; this is what makes a shadow write in the
   // wrap cycle load the old value into duty_act.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_sh  <= '0;
         duty_act <= '0;
         pwm      <= 1'b0;
      end else begin
         if (wr) begin
            duty_sh <= CNT_W'(merge_bytes(32'(duty_sh), wdata, wmask));
         end
         if (load) begin
            duty_act <= duty_sh;
         end
         pwm <= en ? ((cnt < duty_act) ^ inv) : inv;
      end
   end

endmodule

// File: rtl/mmio_pwm.sv
// mmio_pwm: memory-mapped multi-channel PWM peripheral.
//   Bus decode, shared prescaler and period counter, sticky WRAP status,
//   interrupt and registered read mux; NUM_CH pwm_channel instances.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   sel, we, re          peripheral select, write / read strobes
//   addr                 byte offset (addr[1:0] ignored)
//   wdata, wmask         write data, byte-lane enables
//   rdata                registered read data
//   pwm_out              registered PWM outputs
//   irq                  level interrupt, STATUS.WRAP & CTRL.IE
module mmio_pwm
   import pwm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8,
   parameter int PRE_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              we,
   input  logic              re,
   input  logic [7:0]        addr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wmask,
   output logic [31:0]       rdata,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              irq
);

   localparam logic [5:0] NUM_CH_W = 6'(NUM_CH);

   logic [CTRL_W-1:0] ctrl;
   logic [PRE_W-1:0]  prescale;
   logic [PRE_W-1:0]  pre_cnt;
   logic [CNT_W-1:0]  period_sh;
   logic [CNT_W-1:0]  period_act;
   logic [CNT_W-1:0]  cnt;
   logic              wrap_flag;

   logic              en, inv;
   logic              wr_stb, rd_stb;
   logic [7:0]        word_ofs;
   logic [5:0]        duty_idx;
   logic              is_duty;
   logic              tick, wrap, load_act;
   logic              clr_wrap;
   logic [NUM_CH-1:0] duty_wr;
   logic [CNT_W-1:0]  duty_sh [NUM_CH];
   logic [31:0]       rd_mux;
   logic              unused_addr_bits;

   assign en       = ctrl[CTRL_EN];
   assign inv      = ctrl[CTRL_INV];
   assign irq      = wrap_flag & ctrl[CTRL_IE];

   assign wr_stb   = sel & we;
   assign rd_stb   = sel & re;
   assign word_ofs = {addr[7:2], 2'b00};
   assign duty_idx = addr[7:2] - DUTY_BASE[7:2];
   assign is_duty  = (word_ofs >= DUTY_BASE) && (duty_idx < NUM_CH_W);
   assign unused_addr_bits = ^addr[1:0];

   assign tick     = en && (pre_cnt == prescale);
   assign wrap     = tick && (cnt == period_act);
   // While disabled the active copies follow the shadows, so enabling
   // starts straight away with the latest programmed values.
   assign load_act = !en || wrap;
   assign clr_wrap = wr_stb && (word_ofs == STATUS_OFS) && wmask[0] && wdata[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl       <= '0;
         prescale   <= '0;
         pre_cnt    <= '0;
         period_sh  <= '1;
         period_act <= '1;
         cnt        <= '0;
         wrap_flag  <= 1'b0;
         rdata      <= '0;
      end else begin
         if (wr_stb && word_ofs == CTRL_OFS) begin
            ctrl <= CTRL_W'(merge_bytes(32'(ctrl), wdata, wmask));
         end
         if (wr_stb && word_ofs == PRESCALE_OFS) begin
            prescale <= PRE_W'(merge_bytes(32'(prescale), wdata, wmask));
         end
         if (wr_stb && word_ofs == PERIOD_OFS) begin
            period_sh <= CNT_W'(merge_bytes(32'(period_sh), wdata, wmask));
         end

         if (!en) begin
            pre_cnt <= '0;
            cnt     <= '0;
         end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= wrap ? '0 : cnt + 1'b1;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end

         if (load_act) begin
            period_act <= period_sh;
         end

         // A wrap in the same cycle as a W1C wins: the flag stays set.
         if (wrap) begin
            wrap_flag <= 1'b1;
         end else if (clr_wrap) begin
            wrap_flag <= 1'b0;
         end

         if (rd_stb) begin
            rdata <= rd_mux;
         end
      end
   end

   // NOTE: rd_mux gets a default before any branch so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      rd_mux = '0;
      if (word_ofs == CTRL_OFS) begin
         rd_mux = 32'(ctrl);
      end else if (word_ofs == PRESCALE_OFS) begin
         rd_mux = 32'(prescale);
      end else if (word_ofs == PERIOD_OFS) begin
         rd_mux = 32'(period_sh);
      end else if (word_ofs == STATUS_OFS) begin
         rd_mux = 32'(wrap_flag);
      end else if (is_duty) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (duty_idx == 6'(i)) begin
               rd_mux = 32'(duty_sh[i]);
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign duty_wr[i] = wr_stb && is_duty && (duty_idx == 6'(i));

      pwm_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .wr      (duty_wr[i]),
         .wdata   (wdata),
         .wmask   (wmask),
         .load    (load_act),
         .en      (en),
         .inv     (inv),
         .cnt     (cnt),
         .duty_sh (duty_sh[i]),
         .pwm     (pwm_out[i])
      );
   end

endmodule
